// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: one FIFO per functional unit, round-robin pick of up to
// CDB_WIDTH heads per cycle, and registered broadcast slots for the RS, ROB and map table.
module cdb_arbiter #(
    parameter int NUM_FU     = 4,
    parameter int CDB_WIDTH  = 2,
    parameter int FIFO_DEPTH = 2,
    parameter int TAG_W      = 6,
    parameter int XLEN       = 32
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       squash,
    input  logic [NUM_FU-1:0]          fu_valid,
    input  logic [NUM_FU*TAG_W-1:0]    fu_tag,
    input  logic [NUM_FU*XLEN-1:0]     fu_value,
    input  logic [NUM_FU*XLEN-1:0]     fu_npc,
    input  logic [NUM_FU-1:0]          fu_take_branch,
    input  logic [NUM_FU-1:0]          fu_no_write,
    output logic [NUM_FU-1:0]          fu_ready,
    output logic [CDB_WIDTH-1:0]       cdb_valid,
    output logic [CDB_WIDTH-1:0]       cdb_tag_valid,
    output logic [CDB_WIDTH*TAG_W-1:0] cdb_tag,
    output logic [CDB_WIDTH*XLEN-1:0]  cdb_value,
    output logic [CDB_WIDTH*XLEN-1:0]  cdb_npc,
    output logic [CDB_WIDTH-1:0]       cdb_take_branch
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int IDX_W = $clog2(NUM_FU);

    typedef struct packed {
        logic             tag_valid;
        logic             take_branch;
        logic [TAG_W-1:0] tag;
        logic [XLEN-1:0]  value;
        logic [XLEN-1:0]  npc;
    } entry_t;

    entry_t           fifo_mem  [NUM_FU][FIFO_DEPTH];
    logic [PTR_W-1:0] rd_ptr    [NUM_FU];
    logic [PTR_W-1:0] wr_ptr    [NUM_FU];
    logic [CNT_W-1:0] count     [NUM_FU];
    entry_t           push_entry[NUM_FU];
    logic [NUM_FU-1:0] push;
    logic [NUM_FU-1:0] grant;

    logic [IDX_W-1:0]     rr_ptr;
    logic [IDX_W-1:0]     rr_next;
    logic [CDB_WIDTH-1:0] slot_used;
    logic [IDX_W-1:0]     slot_src  [CDB_WIDTH];
    entry_t               slot_entry[CDB_WIDTH];
    int                   arb_idx;
    int                   arb_n;

    // Ready looks only at the registered count, so a same-cycle pop never frees a slot early.
    always_comb begin
        for (int i = 0; i < NUM_FU; i++) begin
            fu_ready[i]               = (count[i] != CNT_W'(FIFO_DEPTH));
            push[i]                   = fu_valid[i] && (count[i] != CNT_W'(FIFO_DEPTH));
            push_entry[i].tag_valid   = !fu_no_write[i];
            push_entry[i].take_branch = fu_take_branch[i];
            push_entry[i].tag         = fu_tag[i*TAG_W +: TAG_W];
            push_entry[i].value       = fu_value[i*XLEN +: XLEN];
            push_entry[i].npc         = fu_take_branch[i] ? fu_value[i*XLEN +: XLEN]
                                                          : fu_npc[i*XLEN +: XLEN];
        end
    end

    // NOTE: every combinational output gets a default before the loop, so no latch is inferred.
    always_comb begin
        grant     = '0;
        slot_used = '0;
        rr_next   = rr_ptr;
        arb_n     = 0;
        arb_idx   = 0;
        for (int s = 0; s < CDB_WIDTH; s++) slot_src[s] = '0;
        for (int k = 0; k < NUM_FU; k++) begin
            arb_idx = (int'(rr_ptr) + k) % NUM_FU;
            if (count[arb_idx] != '0 && arb_n < CDB_WIDTH) begin
                grant[arb_idx]  = 1'b1;
                slot_used[arb_n] = 1'b1;
                slot_src[arb_n]  = IDX_W'(arb_idx);
                rr_next          = IDX_W'((arb_idx + 1) % NUM_FU);
                arb_n            = arb_n + 1;
            end
        end
    end

    always_comb begin
        for (int s = 0; s < CDB_WIDTH; s++) begin
            slot_entry[s] = '0;
            if (slot_used[s]) slot_entry[s] = fifo_mem[slot_src[s]][rd_ptr[slot_src[s]]];
        end
    end

    // NOTE: the storage array has no reset; pointers and counts alone decide which entries are live.
    always_ff @(posedge clock) begin
        for (int i = 0; i < NUM_FU; i++) begin
            if (push[i]) fifo_mem[i][wr_ptr[i]] <= push_entry[i];
        end
    end

    // NOTE: all state updates are non-blocking so every register samples pre-edge values.
    always_ff @(posedge clock) begin
        if (reset || squash) begin
            rr_ptr <= '0;
            for (int i = 0; i < NUM_FU; i++) begin
                rd_ptr[i] <= '0;
                wr_ptr[i] <= '0;
                count[i]  <= '0;
            end
            cdb_valid       <= '0;
            cdb_tag_valid   <= '0;
            cdb_tag         <= '0;
            cdb_value       <= '0;
            cdb_npc         <= '0;
            cdb_take_branch <= '0;
        end else begin
            rr_ptr <= rr_next;
            for (int i = 0; i < NUM_FU; i++) begin
                if (push[i])  wr_ptr[i] <= wr_ptr[i] + PTR_W'(1);
                if (grant[i]) rd_ptr[i] <= rd_ptr[i] + PTR_W'(1);
                case ({push[i], grant[i]})
                    2'b10:   count[i] <= count[i] + CNT_W'(1);
                    2'b01:   count[i] <= count[i] - CNT_W'(1);
                    default: count[i] <= count[i];
                endcase
            end
            for (int s = 0; s < CDB_WIDTH; s++) begin
                cdb_valid[s]                <= slot_used[s];
                cdb_tag_valid[s]            <= slot_entry[s].tag_valid;
                cdb_take_branch[s]          <= slot_entry[s].take_branch;
                cdb_tag[s*TAG_W +: TAG_W]   <= slot_entry[s].tag;
                cdb_value[s*XLEN +: XLEN]   <= slot_entry[s].value;
                cdb_npc[s*XLEN +: XLEN]     <= slot_entry[s].npc;
            end
        end
    end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter: per-producer scoreboard queues filled on accepted
// pushes and drained against every broadcast slot, plus directed scenario checks.
module tb_cdb_arbiter;

    localparam int NUM_FU = 4, CDB_WIDTH = 2, FIFO_DEPTH = 2, TAG_W = 6, XLEN = 32;

    logic clock = 1'b0;
    logic reset, squash;
    logic [NUM_FU-1:0]          fu_valid, fu_take_branch, fu_no_write, fu_ready;
    logic [NUM_FU*TAG_W-1:0]    fu_tag;
    logic [NUM_FU*XLEN-1:0]     fu_value, fu_npc;
    logic [CDB_WIDTH-1:0]       cdb_valid, cdb_tag_valid, cdb_take_branch;
    logic [CDB_WIDTH*TAG_W-1:0] cdb_tag;
    logic [CDB_WIDTH*XLEN-1:0]  cdb_value, cdb_npc;

    cdb_arbiter #(.NUM_FU(NUM_FU), .CDB_WIDTH(CDB_WIDTH), .FIFO_DEPTH(FIFO_DEPTH),
                  .TAG_W(TAG_W), .XLEN(XLEN)) dut (
        .clock(clock), .reset(reset), .squash(squash),
        .fu_valid(fu_valid), .fu_tag(fu_tag), .fu_value(fu_value), .fu_npc(fu_npc),
        .fu_take_branch(fu_take_branch), .fu_no_write(fu_no_write), .fu_ready(fu_ready),
        .cdb_valid(cdb_valid), .cdb_tag_valid(cdb_tag_valid), .cdb_tag(cdb_tag),
        .cdb_value(cdb_value), .cdb_npc(cdb_npc), .cdb_take_branch(cdb_take_branch)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic        tv;
        logic        tb;
        logic [5:0]  tag;
        logic [31:0] value;
        logic [31:0] npc;
    } exp_t;

    exp_t       sb [NUM_FU][$];
    int         total = 0;
    int         bad = 0;
    logic       mon_en = 1'b0;
    logic [3:0] acc;
    logic [3:0] seq [NUM_FU];
    int         pushes [NUM_FU];
    int         limit [NUM_FU];
    int         bcast [NUM_FU];
    exp_t       rec_e, mon_e, mon_got;
    int         mon_f;

    // Record every accepted push as an expected broadcast; reset/squash discards all.
    always @(posedge clock) begin
        acc = '0;
        if (reset || squash) begin
            for (int i = 0; i < NUM_FU; i++) sb[i].delete();
        end else begin
            for (int i = 0; i < NUM_FU; i++) begin
                if (fu_valid[i] && fu_ready[i]) begin
                    rec_e.tv    = !fu_no_write[i];
                    rec_e.tb    = fu_take_branch[i];
                    rec_e.tag   = fu_tag[i*TAG_W +: TAG_W];
                    rec_e.value = fu_value[i*XLEN +: XLEN];
                    rec_e.npc   = fu_take_branch[i] ? fu_value[i*XLEN +: XLEN] : fu_npc[i*XLEN +: XLEN];
                    sb[i].push_back(rec_e);
                    acc[i] = 1'b1;
                end
            end
        end
    end

    // Each valid slot must match the head of some producer queue; idle slots must be all zero.
    always @(negedge clock) begin
        if (mon_en) begin
            for (int s = 0; s < CDB_WIDTH; s++) begin
                mon_got = {cdb_tag_valid[s], cdb_take_branch[s], cdb_tag[s*TAG_W +: TAG_W],
                           cdb_value[s*XLEN +: XLEN], cdb_npc[s*XLEN +: XLEN]};
                total++;
                if (cdb_valid[s] === 1'b1) begin
                    mon_f = -1;
                    for (int f = 0; f < NUM_FU; f++)
                        if (mon_f < 0 && sb[f].size() > 0 && sb[f][0].tag == mon_got.tag) mon_f = f;
                    if (mon_f < 0) begin
                        bad++;
                        $display("FAIL scoreboard slot%0d: got unexpected tag=%h, no queue head matches", s, mon_got.tag);
                    end else begin
                        mon_e = sb[mon_f].pop_front();
                        bcast[mon_f]++;
                        if (mon_got !== mon_e) begin
                            bad++;
                            $display("FAIL scoreboard slot%0d: got %h expected %h", s, mon_got, mon_e);
                        end
                    end
                end else if (cdb_valid[s] !== 1'b0 || mon_got !== '0) begin
                    bad++;
                    $display("FAIL idle_slot%0d: valid=%b fields=%h expected all zero", s, cdb_valid[s], mon_got);
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL timeout: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic offer(input int i);
        fu_tag[i*TAG_W +: TAG_W]  = {i[1:0], seq[i]};
        fu_value[i*XLEN +: XLEN]  = $urandom;
        fu_npc[i*XLEN +: XLEN]    = $urandom;
        fu_take_branch[i]         = 1'($urandom_range(0, 1));
        fu_no_write[i]            = 1'($urandom_range(0, 1));
        fu_valid[i]               = 1'b1;
    endtask

    // Move each producer to its next result once the current one was accepted.
    task automatic advance();
        for (int i = 0; i < NUM_FU; i++) begin
            if (fu_valid[i] && acc[i]) begin
                seq[i] = seq[i] + 4'd1;
                pushes[i]++;
                if (limit[i] == 0 || pushes[i] < limit[i]) offer(i);
                else fu_valid[i] = 1'b0;
            end
        end
    endtask

    task automatic clear_inputs();
        fu_valid = '0; fu_take_branch = '0; fu_no_write = '0;
        fu_tag = '0; fu_value = '0; fu_npc = '0;
        for (int i = 0; i < NUM_FU; i++) begin pushes[i] = 0; limit[i] = 0; end
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic drain(input string name);
        fu_valid = '0;
        repeat (8) tick();
        @(negedge clock);
        #1;
        for (int i = 0; i < NUM_FU; i++) begin
            total++;
            if (sb[i].size() != 0) begin
                bad++;
                $display("FAIL %s_drain fu%0d: %0d results never broadcast, expected 0", name, i, sb[i].size());
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; squash = 1'b0;
        clear_inputs();
        for (int i = 0; i < NUM_FU; i++) begin seq[i] = '0; bcast[i] = 0; end
        tick(); tick();
        total++;
        if (cdb_valid !== 2'b00 || fu_ready !== 4'b1111) begin
            bad++;
            $display("FAIL reset_state: cdb_valid=%b fu_ready=%b expected 00/1111", cdb_valid, fu_ready);
        end
        reset = 1'b0;
        mon_en = 1'b1;
        for (int i = 0; i < NUM_FU; i++) offer(i);
        repeat (4) begin tick(); advance(); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        clear_inputs();
        total++;
        if (cdb_valid !== '0 || cdb_tag_valid !== '0 || cdb_tag !== '0 || cdb_value !== '0 ||
            cdb_npc !== '0 || cdb_take_branch !== '0 || fu_ready !== 4'b1111) begin
            bad++;
            $display("FAIL reset_mid_traffic: cdb_valid=%b fu_ready=%b expected 00/1111 with zero fields",
                     cdb_valid, fu_ready);
        end
        offer(3);
        tick();
        fu_valid = '0;
        total++;
        if (cdb_valid !== 2'b00) begin
            bad++;
            $display("FAIL reset_no_bypass: cdb_valid=%b expected 00 one edge after push", cdb_valid);
        end
        tick();
        total++;
        if (cdb_valid !== 2'b01 || cdb_tag[5:0] !== {2'd3, seq[3]}) begin
            bad++;
            $display("FAIL reset_first_push: cdb_valid=%b tag=%h expected 01/%h", cdb_valid, cdb_tag[5:0], {2'd3, seq[3]});
        end
        drain("reset");
    endtask

    task automatic test_single();
        clear_inputs();
        fu_tag[2*TAG_W +: TAG_W] = 6'd5;
        fu_value[2*XLEN +: XLEN] = 32'h1234;
        fu_npc[2*XLEN +: XLEN]   = 32'h40;
        fu_valid[2] = 1'b1;
        tick();
        fu_valid = '0;
        total++;
        if (cdb_valid !== 2'b00) begin
            bad++;
            $display("FAIL single_latency: cdb_valid=%b expected 00 one edge after push", cdb_valid);
        end
        tick();
        total++;
        if (cdb_valid !== 2'b01 || cdb_tag_valid !== 2'b01 || cdb_tag[5:0] !== 6'd5) begin
            bad++;
            $display("FAIL single_ctrl: valid=%b tag_valid=%b tag=%h expected 01/01/05",
                     cdb_valid, cdb_tag_valid, cdb_tag[5:0]);
        end
        total++;
        if (cdb_value[31:0] !== 32'h1234 || cdb_npc[31:0] !== 32'h40 || cdb_take_branch !== 2'b00) begin
            bad++;
            $display("FAIL single_data: value=%h npc=%h take=%b expected 1234/40/00",
                     cdb_value[31:0], cdb_npc[31:0], cdb_take_branch);
        end
        drain("single");
    endtask

    task automatic test_branch();
        clear_inputs();
        fu_tag[1*TAG_W +: TAG_W] = 6'h11;
        fu_value[1*XLEN +: XLEN] = 32'h200;
        fu_npc[1*XLEN +: XLEN]   = 32'h1f0;
        fu_take_branch[1] = 1'b1;
        fu_no_write[1]    = 1'b1;
        fu_valid[1]       = 1'b1;
        tick();
        fu_valid = '0;
        tick();
        total++;
        if (cdb_valid !== 2'b01 || cdb_tag_valid !== 2'b00 || cdb_npc[31:0] !== 32'h200 ||
            cdb_take_branch !== 2'b01) begin
            bad++;
            $display("FAIL branch: valid=%b tag_valid=%b npc=%h take=%b expected 01/00/200/01",
                     cdb_valid, cdb_tag_valid, cdb_npc[31:0], cdb_take_branch);
        end
        drain("branch");
    endtask

    task automatic test_round_robin();
        logic [1:0] exp0, exp1;
        pulse_reset();
        clear_inputs();
        for (int i = 0; i < NUM_FU; i++) offer(i);
        tick(); advance();
        for (int e = 2; e <= 9; e++) begin
            tick(); advance();
            exp0 = (e % 2 == 0) ? 2'd0 : 2'd2;
            exp1 = (e % 2 == 0) ? 2'd1 : 2'd3;
            total++;
            if (cdb_valid !== 2'b11 || cdb_tag[5:4] !== exp0 || cdb_tag[11:10] !== exp1) begin
                bad++;
                $display("FAIL round_robin edge%0d: valid=%b grants={%0d,%0d} expected 11/{%0d,%0d}",
                         e, cdb_valid, cdb_tag[5:4], cdb_tag[11:10], exp0, exp1);
            end
        end
        drain("round_robin");
    endtask

    task automatic test_backpressure();
        int b0;
        pulse_reset();
        clear_inputs();
        offer(1);
        tick();
        fu_valid = '0;
        tick();
        b0 = bcast[0];
        for (int i = 0; i < NUM_FU; i++) begin pushes[i] = 0; limit[i] = 0; end
        limit[0] = 3;
        for (int i = 0; i < NUM_FU; i++) offer(i);
        tick(); advance();
        tick(); advance();
        total++;
        if (fu_ready !== 4'b1100) begin
            bad++;
            $display("FAIL backpressure_full: fu_ready=%b expected 1100", fu_ready);
        end
        tick(); advance();
        total++;
        if (fu_ready !== 4'b0011) begin
            bad++;
            $display("FAIL backpressure_release: fu_ready=%b expected 0011", fu_ready);
        end
        for (int k = 0; k < 10 && pushes[0] < 3; k++) begin tick(); advance(); end
        total++;
        if (pushes[0] != 3) begin
            bad++;
            $display("FAIL backpressure_retry: fu0 accepted %0d pushes expected 3", pushes[0]);
        end
        drain("backpressure");
        total++;
        if (bcast[0] - b0 != 3) begin
            bad++;
            $display("FAIL backpressure_count: fu0 broadcast %0d results expected 3", bcast[0] - b0);
        end
    endtask

    task automatic test_squash();
        pulse_reset();
        clear_inputs();
        for (int i = 0; i < NUM_FU; i++) offer(i);
        tick();
        for (int i = 0; i < NUM_FU; i++) seq[i] = seq[i] + 4'd1;
        fu_valid = '0;
        offer(0); offer(2); offer(3);
        tick();
        for (int i = 0; i < NUM_FU; i++) seq[i] = seq[i] + 4'd1;
        for (int i = 0; i < NUM_FU; i++) offer(i);
        squash = 1'b1;
        tick();
        squash = 1'b0;
        fu_valid = '0;
        total++;
        if (cdb_valid !== 2'b00 || fu_ready !== 4'b1111) begin
            bad++;
            $display("FAIL squash_flush: cdb_valid=%b fu_ready=%b expected 00/1111", cdb_valid, fu_ready);
        end
        for (int k = 0; k < 5; k++) begin
            tick();
            total++;
            if (cdb_valid !== 2'b00) begin
                bad++;
                $display("FAIL squash_leak cycle%0d: cdb_valid=%b expected 00", k, cdb_valid);
            end
        end
        for (int i = 0; i < NUM_FU; i++) begin seq[i] = seq[i] + 4'd1; offer(i); end
        tick();
        fu_valid = '0;
        tick();
        total++;
        if (cdb_valid !== 2'b11 || cdb_tag[5:4] !== 2'd0 || cdb_tag[11:10] !== 2'd1) begin
            bad++;
            $display("FAIL squash_rr_ptr: valid=%b grants={%0d,%0d} expected 11/{0,1}",
                     cdb_valid, cdb_tag[5:4], cdb_tag[11:10]);
        end
        drain("squash");
    endtask

    initial begin
        test_reset();
        test_single();
        test_branch();
        test_round_robin();
        test_backpressure();
        test_squash();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
